ps2_scancode_sequencer: RTL and testbench
=========================================

PS2_SCANCODE_SEQUENCER -- requirements
Module: ps2_scancode_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, key-event FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT_CYC, default 50000, clk cycles allowed between a prefix byte and its follow-up.
REQ-003 clk  in  1  system clock; all logic is single-clock on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 code  in  8  received PS/2 byte, from the PS/2 receiver.
REQ-006 code_valid  in  1  one-cycle strobe; code is valid this cycle.
REQ-007 code_error  in  1  receiver framing/parity error; sampled only when code_valid=1.
REQ-008 evt_code  out  8  key scan code at FIFO head.
REQ-009 evt_ext  out  1  head event carried an E0 prefix.
REQ-010 evt_release  out  1  head event is a break (F0) event.
REQ-011 evt_valid  out  1  FIFO non-empty.
REQ-012 evt_ready  in  1  consumer accepts head when evt_valid&evt_ready.
REQ-013 shift_held  out  1  left (12h) or right (59h) shift currently pressed.
REQ-014 caps_lock  out  1  caps-lock toggle state.
REQ-015 overflow  out  1  sticky; an event was dropped because the FIFO was full.
REQ-016 overflow_clr  in  1  clears overflow; loses to a same-cycle set.
REQ-017 err_count  out  8  saturating count of code_error strobes.

Function
REQ-018 Decode FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-019 IDLE: E0->EXT; F0->BRK; FAh/AAh/00h/FFh ignored; E1h pushed as a make event; any other byte pushes a make event {code, ext=0, rel=0}.
REQ-020 EXT: F0->EXT_BRK; E0 stays in EXT; other byte pushes {code, ext=1, rel=0} and returns to IDLE.
REQ-021 BRK: any byte except E0/F0 pushes {code, 0, 1} and returns to IDLE; E0/F0 return to IDLE without a push.
REQ-022 EXT_BRK: any byte except E0/F0 pushes {code, 1, 1} and returns to IDLE; E0/F0 return to IDLE without a push.
REQ-023 A code_valid with code_error=1 forces IDLE, pushes nothing, and increments err_count, which saturates at FFh.
REQ-024 Timeout counter clears on each code_valid; in any non-IDLE state, reaching TIMEOUT_CYC forces IDLE with no push.
REQ-025 Latency: code_valid at cycle N with an empty FIFO gives evt_valid=1 with the event fields at cycle N+1.
REQ-026 FIFO is show-ahead; head fields hold stable while evt_valid=1 and evt_ready=0.
REQ-027 Full FIFO, push, no pop: the event is dropped, overflow is set, and the FIFO is unchanged.
REQ-028 Full FIFO, push and pop in the same cycle: both succeed and occupancy stays full.
REQ-029 Empty FIFO with evt_ready=1 and no push: no change; the read pointer does not move.
REQ-030 Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with an extra pointer bit.
REQ-031 shift_held and caps_lock update on the event decode, independent of FIFO room.
REQ-032 shift_held tracks non-extended 12h/59h make and break events; it is 1 while either key is held (two tracking flops).
REQ-033 caps_lock toggles on a non-extended 58h make event only when the previous 58h event was a break, so typematic repeats are ignored.
REQ-034 Typematic repeat makes of all other keys are pushed unfiltered.

Reset
REQ-035 rst_n low asynchronously sets: FSM to IDLE, FIFO empty (evt_valid=0), evt_code=00h, evt_ext=0, evt_release=0, shift_held=0, caps_lock=0, overflow=0, err_count=0, timeout counter=0.
REQ-036 Reset asserted mid-sequence (for example after E0) discards the partial sequence; the first byte after release is decoded from IDLE.

Structure
REQ-037 A shared package ps2_pkg holds: the FSM state enum, the key-event struct {code, ext, release}, and the constants E0h, F0h, FAh, AAh, 12h, 59h, 58h.
REQ-038 One sub-module, ps2_evt_fifo (parameterised depth, event struct, valid/ready output side), is instantiated once.

Verification
REQ-039 Bytes 1Ch, then F0h 1Ch -> two events: {1Ch,0,0} then {1Ch,0,1}.
REQ-040 Bytes E0h 75h, then E0h F0h 75h -> events {75h,1,0} then {75h,1,1}.
REQ-041 E0h, then idle for TIMEOUT_CYC cycles, then 1Ch -> single event {1Ch,0,0}.
REQ-042 evt_ready=0 and six make codes with FIFO_DEPTH=4 -> four events held in order, overflow=1; overflow_clr -> overflow=0.
REQ-043 Bytes 58h 58h F0h 58h 58h -> caps_lock goes 0->1, stays 1, then goes 1->0 on the second make.
REQ-044 F0h then a code with code_error=1 -> no event, err_count=1; the next byte 1Ch gives {1Ch,0,0}.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 scan-code sequencer.
// The event's break flag is called "rel" because "release" is a reserved word.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_evt_t;

  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_BAT    = 8'hAA;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  // Keyboard housekeeping bytes that never become key events.
  function automatic logic is_filler(input logic [7:0] c);
    return (c == CODE_ACK) || (c == CODE_BAT) || (c == 8'h00) || (c == 8'hFF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] c);
    return (c == CODE_E0) || (c == CODE_F0);
  endfunction

endpackage

// File: rtl/ps2_scancode_sequencer_if.sv
// Byte-in / key-event-out bundle of the scan-code sequencer.
interface ps2_scancode_sequencer_if;
  logic [7:0] code;
  logic       code_valid;
  logic       code_error;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;
  logic       evt_valid;
  logic       evt_ready;

  modport master (
    output code, code_valid, code_error, evt_ready,
    input  evt_code, evt_ext, evt_release, evt_valid
  );

  modport slave (
    input  code, code_valid, code_error, evt_ready,
    output evt_code, evt_ext, evt_release, evt_valid
  );
endinterface

// File: rtl/ps2_evt_fifo.sv
// Show-ahead key-event FIFO; a push into a full FIFO is dropped unless a pop
// happens in the same cycle, and the drop is reported so the caller can flag it.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  key_evt_t push_evt,
  output logic     drop,
  output key_evt_t head,
  output logic     head_valid,
  input  logic     head_ready
);

  localparam int AW = $clog2(DEPTH);

  key_evt_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = head_ready && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_evt;
  end

  // Head reads as zero while empty so the outputs are defined out of reset.
  assign head_valid = !empty;
  assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_scancode_sequencer.sv
// Decodes PS/2 prefix sequences into key events, tracks shift/caps state
// and queues events for a valid/ready consumer.
//
// state      | meaning
// -----------+-------------------------------------------
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen, waiting for key byte or F0
// ST_BRK     | F0 seen, waiting for key byte
// ST_EXT_BRK | E0 F0 seen, waiting for key byte
module ps2_scancode_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ps2_scancode_sequencer_if.slave   bus,
  input  logic                      overflow_clr,
  output logic                      shift_held,
  output logic                      caps_lock,
  output logic                      overflow,
  output logic [7:0]                err_count
);

  localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

  dec_state_t    state;
  dec_state_t    state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          byte_ok;
  logic          code_err;
  logic          push;
  key_evt_t      push_evt;
  logic          fifo_drop;
  key_evt_t      head;
  logic          lshift;
  logic          rshift;
  logic          caps_armed;

  assign byte_ok  = bus.code_valid && !bus.code_error;
  assign code_err = bus.code_valid && bus.code_error;
  assign tmo_hit  = (state != ST_IDLE) && !bus.code_valid && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (code_err || tmo_hit) begin
      state_nxt = ST_IDLE;
    end else if (byte_ok) begin
      case (state)
        ST_IDLE: begin
          if (bus.code == CODE_E0)      state_nxt = ST_EXT;
          else if (bus.code == CODE_F0) state_nxt = ST_BRK;
        end
        ST_EXT: begin
          if (bus.code == CODE_F0)      state_nxt = ST_EXT_BRK;
          else if (bus.code != CODE_E0) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push         = 1'b0;
    push_evt     = '0;
    push_evt.code = bus.code;
    if (byte_ok) begin
      case (state)
        ST_IDLE: push = !is_prefix(bus.code) && !is_filler(bus.code);
        ST_EXT: begin
          push         = !is_prefix(bus.code);
          push_evt.ext = 1'b1;
        end
        ST_BRK: begin
          push         = !is_prefix(bus.code);
          push_evt.rel = 1'b1;
        end
        default: begin
          push         = !is_prefix(bus.code);
          push_evt.ext = 1'b1;
          push_evt.rel = 1'b1;
        end
      endcase
    end
  end

  // Up-counter measuring silence after a prefix byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             tmo_cnt <= '0;
    else if (state == ST_IDLE || bus.code_valid || tmo_hit) tmo_cnt <= '0;
    else                                                    tmo_cnt <= tmo_cnt + 1'b1;
  end

  // caps_armed remembers that the last caps event was a break, so held-key repeats don't toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      caps_lock  <= 1'b0;
      caps_armed <= 1'b1;
    end else if (push && !push_evt.ext) begin
      case (push_evt.code)
        CODE_LSHIFT: lshift <= !push_evt.rel;
        CODE_RSHIFT: rshift <= !push_evt.rel;
        CODE_CAPS: begin
          if (push_evt.rel) begin
            caps_armed <= 1'b1;
          end else begin
            if (caps_armed) caps_lock <= !caps_lock;
            caps_armed <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign shift_held = lshift || rshift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (fifo_drop)    overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_count <= '0;
    else if (code_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_evt   (push_evt),
    .drop       (fifo_drop),
    .head       (head),
    .head_valid (bus.evt_valid),
    .head_ready (bus.evt_ready)
  );

  assign bus.evt_code    = head.code;
  assign bus.evt_ext     = head.ext;
  assign bus.evt_release = head.rel;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Scoreboard bench: stimulus queues expected events, a monitor checks each accepted head.
module tb_ps2_scancode_sequencer;
  import ps2_pkg::*;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       shift_held;
  logic       caps_lock;
  logic       overflow;
  logic [7:0] err_count;

  key_evt_t exp_q[$];
  int       n_cmp = 0;
  int       n_bad = 0;

  ps2_scancode_sequencer_if bus();

  ps2_scancode_sequencer #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .overflow_clr (overflow_clr),
    .shift_held   (shift_held),
    .caps_lock    (caps_lock),
    .overflow     (overflow),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.evt_valid && bus.evt_ready) begin
      key_evt_t got;
      key_evt_t want;
      got = '{code: bus.evt_code, ext: bus.evt_ext, rel: bus.evt_release};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL evt_unexpected: got %h/%b/%b, required no event", got.code, got.ext, got.rel);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL evt_head: got %h/%b/%b, required %h/%b/%b",
                   got.code, got.ext, got.rel, want.code, want.ext, want.rel);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic err = 1'b0);
    @(posedge clk); #1;
    bus.code       = c;
    bus.code_error = err;
    bus.code_valid = 1'b1;
    @(posedge clk); #1;
    bus.code_valid = 1'b0;
    bus.code_error = 1'b0;
  endtask

  task automatic expect_evt(input logic [7:0] c, input logic e, input logic r);
    exp_q.push_back('{code: c, ext: e, rel: r});
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] fill [6];
    fill = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
    bus.code = '0;
    bus.code_valid = 1'b0;
    bus.code_error = 1'b0;
    bus.evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_evt_valid", bus.evt_valid, 0);
    chk("rst_evt_code", bus.evt_code, 0);
    chk("rst_evt_ext", bus.evt_ext, 0);
    chk("rst_evt_release", bus.evt_release, 0);
    chk("rst_shift", shift_held, 0);
    chk("rst_caps", caps_lock, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    bus.evt_ready = 1'b1;

    // plain make/break and extended make/break
    expect_evt(8'h1C, 0, 0); send(8'h1C);
    expect_evt(8'h1C, 0, 1); send(8'hF0); send(8'h1C);
    expect_evt(8'h75, 1, 0); send(8'hE0); send(8'h75);
    expect_evt(8'h75, 1, 1); send(8'hE0); send(8'hF0); send(8'h75);
    // housekeeping bytes dropped, E1 passes as a make
    send(8'hFA); send(8'hAA); send(8'h00); send(8'hFF);
    expect_evt(8'hE1, 0, 0); send(8'hE1);
    // F0 then E0 abandons the break; E0 E0 stays extended
    send(8'hF0); send(8'hE0);
    expect_evt(8'h1C, 0, 0); send(8'h1C);
    send(8'hE0); send(8'hE0);
    expect_evt(8'h6B, 1, 0); send(8'h6B);
    // prefix timeout and just-before-timeout
    send(8'hE0); repeat (TMO + 2) @(posedge clk);
    expect_evt(8'h1C, 0, 0); send(8'h1C);
    send(8'hE0); repeat (TMO - 3) @(posedge clk);
    expect_evt(8'h75, 1, 0); send(8'h75);
    wait_drain();

    // shift tracking
    expect_evt(8'h12, 0, 0); send(8'h12);
    chk("shift_l_make", shift_held, 1);
    expect_evt(8'h59, 0, 0); send(8'h59);
    expect_evt(8'h12, 0, 1); send(8'hF0); send(8'h12);
    chk("shift_r_still", shift_held, 1);
    expect_evt(8'h59, 0, 1); send(8'hF0); send(8'h59);
    chk("shift_both_up", shift_held, 0);
    expect_evt(8'h12, 1, 0); send(8'hE0); send(8'h12);
    chk("shift_ext_ignored", shift_held, 0);
    expect_evt(8'h12, 1, 1); send(8'hE0); send(8'hF0); send(8'h12);

    // caps lock with typematic repeat
    expect_evt(8'h58, 0, 0); send(8'h58);
    chk("caps_first_make", caps_lock, 1);
    expect_evt(8'h58, 0, 0); send(8'h58);
    chk("caps_repeat", caps_lock, 1);
    expect_evt(8'h58, 0, 1); send(8'hF0); send(8'h58);
    chk("caps_break", caps_lock, 1);
    expect_evt(8'h58, 0, 0); send(8'h58);
    chk("caps_second_make", caps_lock, 0);

    // receiver errors
    send(8'hF0); send(8'h1C, 1'b1);
    chk("err_one", err_count, 1);
    expect_evt(8'h1C, 0, 0); send(8'h1C);
    for (int i = 0; i < 256; i++) send(8'h33, 1'b1);
    chk("err_saturate", err_count, 8'hFF);
    wait_drain();

    // FIFO fill, overflow, clear priority, full push+pop
    bus.evt_ready = 1'b0;
    expect_evt(fill[0], 0, 0); send(fill[0]);
    chk("latency_valid", bus.evt_valid, 1);
    chk("latency_code", bus.evt_code, 8'h15);
    for (int i = 1; i < 4; i++) begin
      expect_evt(fill[i], 0, 0); send(fill[i]);
    end
    chk("full_no_overflow", overflow, 0);
    send(fill[4]); send(fill[5]);
    chk("overflow_set", overflow, 1);
    chk("head_stable", bus.evt_code, 8'h15);
    pulse_clr();
    chk("overflow_clr", overflow, 0);
    @(posedge clk); #1;
    bus.code = 8'h3C; bus.code_valid = 1'b1; overflow_clr = 1'b1;
    @(posedge clk); #1;
    bus.code_valid = 1'b0; overflow_clr = 1'b0;
    chk("overflow_set_wins", overflow, 1);
    pulse_clr();
    chk("overflow_clr2", overflow, 0);
    expect_evt(8'h43, 0, 0);
    @(posedge clk); #1;
    bus.code = 8'h43; bus.code_valid = 1'b1; bus.evt_ready = 1'b1;
    @(posedge clk); #1;
    bus.code_valid = 1'b0; bus.evt_ready = 1'b0;
    chk("full_pushpop_no_ovf", overflow, 0);
    chk("full_pushpop_head", bus.evt_code, 8'h1D);
    send(8'h4E);
    chk("still_full", overflow, 1);
    pulse_clr();
    bus.evt_ready = 1'b1;
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    chk("empty_ready_idle", bus.evt_valid, 0);

    // reset mid-sequence discards the E0
    send(8'hE0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_err", err_count, 0);
    chk("midrst_valid", bus.evt_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_evt(8'h75, 0, 0); send(8'h75);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
